// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle unsigned shift-and-add multiplier controller.
//
// The block runs one WIDTH-bit ripple adder over WIDTH iterations. A
// start/busy/done handshake frames each request, and the 2*WIDTH-bit product
// is registered. It sits in the RV32M MUL/MULHU execute path.
//
// Optional feature macro: MUL_EARLY_TERM_EN
//   When defined, a zero operand on the accepting edge skips the iterations.
//   The block goes straight to DONE with a zero product (latency 1).
//   When undefined, no zero-detect logic exists and every operand pair takes
//   the full iterative latency.

// Plain ripple-carry adder: one full-adder cell per bit.
module adder #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] operandA,
    input  logic [SIZE-1:0] operandB,
    input  logic            carryIn,
    output logic [SIZE-1:0] sum,
    output logic            carryOut
);

    logic [SIZE:0] carry;

    assign carry[0] = carryIn;

    // Carry ripples bit by bit; bit i consumes carry[i] and produces carry[i+1].
    for (genvar i = 0; i < SIZE; i++) begin : g_fa
        assign sum[i]       = operandA[i] ^ operandB[i] ^ carry[i];
        assign carry[i + 1] = (operandA[i] & operandB[i]) |
                              (carry[i] & (operandA[i] ^ operandB[i]));
    end

    assign carryOut = carry[SIZE];

endmodule

module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Counter must hold values up to WIDTH.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       acc_q;      // high partial product
    logic [WIDTH-1:0]       mq_q;       // multiplier, shifting into low product bits
    logic [WIDTH-1:0]       mcand_q;    // captured multiplicand
    logic [CNT_W-1:0]       cnt_q;      // iterations completed
    logic                   busy_q;
    logic                   done_q;
    logic [2*WIDTH-1:0]     product_q;

    // Adder hookup and next values for one shift-add iteration.
    logic [WIDTH-1:0]       add_b;
    logic [WIDTH-1:0]       add_sum;
    logic                   add_cout;
    logic [WIDTH-1:0]       acc_d;
    logic [WIDTH-1:0]       mq_d;
    logic [CNT_W-1:0]       cnt_d;
    logic [2*WIDTH-1:0]     product_d;
    logic                   last_iter;

    // The only adder in the multiply path; the carry-in is never used.
    adder #(
        .SIZE (WIDTH)
    ) u_adder (
        .operandA (acc_q),
        .operandB (add_b),
        .carryIn  (1'b0),
        .sum      (add_sum),
        .carryOut (add_cout)
    );

    // One iteration: add mcand when the current multiplier LSB is set, then
    // shift {carry, sum, mq} right by one. The carry-out becomes acc's MSB, so
    // no bit of the 2*WIDTH result is lost.
    always_comb begin
        add_b     = mq_q[0] ? mcand_q : '0;
        acc_d     = {add_cout, add_sum[WIDTH-1:1]};
        mq_d      = {add_sum[0], mq_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CNT_W'(1);
        product_d = {add_cout, add_sum, mq_q[WIDTH-1:1]};
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM plus datapath registers; reset discards any in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= '0;
                        mq_q    <= multiplier;
                        mcand_q <= multiplicand;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef MUL_EARLY_TERM_EN
                        // A zero operand gives a zero product, so the
                        // iterations are skipped.
                        if ((multiplicand == '0) || (multiplier == '0)) begin
                            product_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            state_q   <= RUN;
                        end
`else
                        state_q <= RUN;
`endif
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                RUN: begin
                    acc_q <= acc_d;
                    mq_q  <= mq_d;
                    cnt_q <= cnt_d;
                    if (last_iter) begin
                        product_q <= product_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl (WIDTH = 32).
// The driver issues requests. A reference model predicts every accepted
// request with plain arithmetic (A*B) and the cycle its done is due. A monitor
// compares busy, done and product against those predictions on every cycle.
module tb_mul_seq_ctrl;

    localparam int WIDTH = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    mul_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int                 done_cyc;
    } exp_t;

    exp_t               q[$];
    int                 cyc         = 0;    // posedges seen so far
    int                 busy_until  = -1;   // last sample index where busy is expected
    int                 n_acc       = 0;
    bit                 rst_pending = 1'b0;
    logic [2*WIDTH-1:0] held        = '0;
    int                 n_cmp       = 0;
    int                 n_bad       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*WIDTH-1:0] act,
                       input logic [2*WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor and reference model, sampled mid-cycle, well away from posedge.
    always begin
        logic               exp_busy;
        logic               exp_done;
        logic               early;
        int                 dc;
        @(negedge clk);
        #2;
        if (rst_pending) begin
            chk("reset_busy", {63'd0, busy}, '0);
            chk("reset_done", {63'd0, done}, '0);
            chk("reset_product", product, '0);
            rst_pending = 1'b0;
        end
        exp_busy = (cyc <= busy_until);
        chk("busy", {63'd0, busy}, {63'd0, exp_busy});
        exp_done = (q.size() != 0) && (q[0].done_cyc == cyc);
        chk("done", {63'd0, done}, {63'd0, exp_done});
        if (exp_done) begin
            chk("product", product, q[0].prod);
            held = q[0].prod;
            void'(q.pop_front());
        end else begin
            chk("product_hold", product, held);
        end
        // Predict the effect of the coming edge from the current inputs.
        if (reset) begin
            q.delete();
            busy_until  = -1;
            held        = '0;
            rst_pending = 1'b1;
        end else if (start && !exp_busy) begin
`ifdef MUL_EARLY_TERM_EN
            early = (multiplicand == '0) || (multiplier == '0);
`else
            early = 1'b0;
`endif
            dc = cyc + 1 + (early ? 0 : WIDTH);
            q.push_back('{prod: 64'(multiplicand) * 64'(multiplier), done_cyc: dc});
            busy_until = dc;
            n_acc++;
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((q.size() != 0 || busy_until >= cyc) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: model still busy after %0d cycles, limit 500", guard);
        end
    endtask

    initial begin
        int base;
        int g;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        issue(32'd3, 32'd5);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();

        // Second request while busy must be ignored.
        issue(32'd7, 32'd9);
        repeat (8) @(negedge clk);
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // Reset mid-run discards the operation.
        issue(32'd9, 32'd11);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'd4, 32'd4);
        wait_idle();

        // Reset wins over start on the same edge.
        @(negedge clk);
        reset        = 1'b1;
        start        = 1'b1;
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        issue(32'd0, 32'h1234);
        wait_idle();

        // Back-to-back with start held high.
        base = n_acc;
        @(negedge clk);
        multiplicand = 32'd6;
        multiplier   = 32'd7;
        start        = 1'b1;
        @(negedge clk);
        multiplicand = 32'd10;
        multiplier   = 32'd10;
        g = 0;
        while (n_acc < base + 2 && g < 200) begin
            @(negedge clk);
            g++;
        end
        start = 1'b0;
        wait_idle();

        // Randomized requests, stray starts, and occasional mid-run resets.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = '0;
                1:       ra = '1;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = '1;
                default: rb = $urandom;
            endcase
            issue(ra, rb);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                multiplicand = $urandom;
                multiplier   = $urandom;
                start        = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, 25)) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
